// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - UART 8N1 dump of the mem20..mem30 window: header, 11 snapshot bytes, checksum
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mem20,
  input  logic [7:0] mem21,
  input  logic [7:0] mem22,
  input  logic [7:0] mem23,
  input  logic [7:0] mem24,
  input  logic [7:0] mem25,
  input  logic [7:0] mem26,
  input  logic [7:0] mem27,
  input  logic [7:0] mem28,
  input  logic [7:0] mem29,
  input  logic [7:0] mem30,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int             CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]     HEADER  = 8'hA5;
  localparam logic [3:0]     LAST_BYTE = 4'd12;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       snap [11];
  logic [7:0]       mem_in [11];
  logic [7:0]       chk;
  logic [3:0]       byte_idx;
  logic [3:0]       snap_idx;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cur;
  logic             bit_end;

  assign mem_in[0]  = mem20;
  assign mem_in[1]  = mem21;
  assign mem_in[2]  = mem22;
  assign mem_in[3]  = mem23;
  assign mem_in[4]  = mem24;
  assign mem_in[5]  = mem25;
  assign mem_in[6]  = mem26;
  assign mem_in[7]  = mem27;
  assign mem_in[8]  = mem28;
  assign mem_in[9]  = mem29;
  assign mem_in[10] = mem30;

  assign bit_end  = (cnt == CNT_MAX);
  assign snap_idx = byte_idx - 4'd1;

  always_comb begin
    cur = HEADER;
    if (byte_idx == LAST_BYTE)
      cur = chk;
    else if (byte_idx != 4'd0)
      cur = snap[snap_idx];
  end

  // Checksum accumulates each data byte as its start bit ends, so it is
  // complete before byte 12 needs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      chk      <= '0;
      for (int i = 0; i < 11; i++) snap[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            for (int i = 0; i < 11; i++) snap[i] <= mem_in[i];
            chk      <= '0;
            byte_idx <= '0;
            cnt      <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= cur[0];
            state   <= DATA;
            if (byte_idx != 4'd0 && byte_idx != LAST_BYTE) chk <= chk + cur;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 4'd1;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb/tb_mem_dump_tx.sv - directed bench for mem_dump_tx at CLKS_PER_BIT 4 and 2
module tb_mem_dump_tx;

  logic       clk;
  logic       rst_n;
  logic       start4, start2;
  logic [7:0] m4 [11];
  logic [7:0] m2 [11];
  logic       tx4, busy4, done4, tx2, busy2, done2;
  logic       sel;
  logic       tx_s, busy_s, done_s;
  logic [7:0] exp_b [13];
  int         checks = 0;
  int         errors = 0;

  mem_dump_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .mem20(m4[0]), .mem21(m4[1]), .mem22(m4[2]), .mem23(m4[3]), .mem24(m4[4]),
    .mem25(m4[5]), .mem26(m4[6]), .mem27(m4[7]), .mem28(m4[8]), .mem29(m4[9]),
    .mem30(m4[10]), .tx(tx4), .busy(busy4), .done(done4)
  );

  mem_dump_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .mem20(m2[0]), .mem21(m2[1]), .mem22(m2[2]), .mem23(m2[3]), .mem24(m2[4]),
    .mem25(m2[5]), .mem26(m2[6]), .mem27(m2[7]), .mem28(m2[8]), .mem29(m2[9]),
    .mem30(m2[10]), .tx(tx2), .busy(busy2), .done(done2)
  );

  assign tx_s   = sel ? tx2   : tx4;
  assign busy_s = sel ? busy2 : busy4;
  assign done_s = sel ? done2 : done4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start2 = v; else start4 = v;
  endtask

  task automatic set_mem(input bit s, input logic [7:0] v0, input logic [7:0] step);
    for (int i = 0; i < 11; i++) begin
      if (s) m2[i] = v0 + step * 8'(i); else m4[i] = v0 + step * 8'(i);
    end
  endtask

  task automatic set_exp(input logic [7:0] v0, input logic [7:0] step, input logic [7:0] sum);
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 11; i++) exp_b[i+1] = v0 + step * 8'(i);
    exp_b[12] = sum;
  endtask

  // mode: 0 plain, 1 zero mem after accept, 2 restart at byte 5,
  // 3 reset in byte 7 data, 4 hold start through done
  task automatic run_frame(input bit s, input int c, input int mode, input string tag);
    logic [7:0] b [13];
    bit timing_ok, busy_ok, aborted;
    logic lvl, first_lvl;
    int bs, by, pos;
    timing_ok = 1; busy_ok = 1; aborted = 0; first_lvl = 1'b0;
    for (int i = 0; i < 13; i++) b[i] = 8'h00;
    sel = s;
    @(negedge clk);
    chk({tag, " busy_before"}, busy_s, 1'b0);
    set_start(s, 1'b1);
    @(negedge clk);
    if (mode != 4) set_start(s, 1'b0);
    for (int k = 0; k < 130 * c && !aborted; k++) begin
      if (k > 0) @(negedge clk);
      bs = k / c; by = bs / 10; pos = bs % 10;
      lvl = tx_s;
      if (k % c == 0) first_lvl = lvl;
      else if (lvl !== first_lvl) timing_ok = 0;
      if (pos == 0 && lvl !== 1'b0) timing_ok = 0;
      if (pos == 9 && lvl !== 1'b1) timing_ok = 0;
      if (pos >= 1 && pos <= 8 && k % c == 0) b[by][pos-1] = lvl;
      if (busy_s !== 1'b1 || done_s !== 1'b0) busy_ok = 0;
      if (mode == 1 && k == 0) set_mem(s, 8'h00, 8'h00);
      if (mode == 2 && by == 5 && pos == 0 && k % c == 0) set_start(s, 1'b1);
      if (mode == 2 && by == 5 && pos == 0 && k % c == 1) set_start(s, 1'b0);
      if (mode == 3 && by == 7 && pos == 3) begin
        rst_n = 1'b0;
        #1;
        chk({tag, " rst_tx"}, tx_s, 1'b1);
        chk({tag, " rst_busy"}, busy_s, 1'b0);
        chk({tag, " rst_done"}, done_s, 1'b0);
        @(negedge clk);
        chk({tag, " rst_done_held"}, done_s, 1'b0);
        rst_n = 1'b1;
        aborted = 1;
      end
    end
    if (!aborted) begin
      chk({tag, " bit_timing"}, timing_ok, 1'b1);
      chk({tag, " busy_window"}, busy_ok, 1'b1);
      for (int i = 0; i < 13; i++) chk($sformatf("%s byte%0d", tag, i), b[i], exp_b[i]);
      @(negedge clk);
      chk({tag, " end_busy"}, busy_s, 1'b0);
      chk({tag, " end_done"}, done_s, 1'b1);
      chk({tag, " end_tx"}, tx_s, 1'b1);
      @(negedge clk);
      chk({tag, " done_clear"}, done_s, 1'b0);
      if (mode == 4) begin
        chk({tag, " restart_busy"}, busy_s, 1'b1);
        chk({tag, " restart_tx"}, tx_s, 1'b0);
        set_start(s, 1'b0);
      end else begin
        chk({tag, " idle_busy"}, busy_s, 1'b0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start4 = 1'b0; start2 = 1'b0; sel = 1'b0;
    set_mem(0, 8'h00, 8'h00);
    set_mem(1, 8'h00, 8'h00);
    #22;
    chk("reset tx4", tx4, 1'b1);
    chk("reset busy4", busy4, 1'b0);
    chk("reset done4", done4, 1'b0);
    chk("reset tx2", tx2, 1'b1);
    chk("reset busy2", busy2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    set_mem(0, 8'h01, 8'h01); set_exp(8'h01, 8'h01, 8'h42);
    run_frame(0, 4, 0, "seq");

    set_mem(0, 8'hFF, 8'h00); set_exp(8'hFF, 8'h00, 8'hF5);
    run_frame(0, 4, 0, "allff");

    set_mem(0, 8'h11, 8'h11); set_exp(8'h11, 8'h11, 8'h62);
    run_frame(0, 4, 1, "snap");

    set_mem(0, 8'h01, 8'h01); set_exp(8'h01, 8'h01, 8'h42);
    run_frame(0, 4, 2, "restart");
    run_frame(0, 4, 4, "hold");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    set_mem(0, 8'hFF, 8'h00); set_exp(8'hFF, 8'h00, 8'hF5);
    run_frame(0, 4, 3, "abort");
    run_frame(0, 4, 0, "after_rst");

    set_mem(1, 8'h80, 8'h00); set_exp(8'h80, 8'h00, 8'h80);
    run_frame(1, 2, 0, "cpb2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
